// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter/sequencer for the shared result registers a..d.
// Build option WR_ARB_ACCUM_EN: commits accumulate (reg + data) instead of overwriting.
module reg_write_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8,
    parameter int unsigned CW   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [2*NREQ-1:0]    req_addr,
    input  logic [DW*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ack,
    output logic [DW-1:0]        a,
    output logic [DW-1:0]        b,
    output logic [DW-1:0]        c,
    output logic [DW-1:0]        d,
    output logic                 busy,
    output logic [CW-1:0]        commit_cnt
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;

    logic [0:0]      state;
    logic [0:0]      next_state;
    logic [IW-1:0]   win;
    logic [IW-1:0]   win_inc;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   base;
    logic [IW-1:0]   grant;
    logic            found;
    logic [1:0]      sel_addr;
    logic [DW-1:0]   sel_data;
    logic [1:0]      lat_addr;
    logic [DW-1:0]   lat_data;
    logic [DW-1:0]   wdata;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] ack_next;
    logic [DW-1:0]   regs [4];

    assign win_inc = (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
    // While writing, the scan starts after the committing winner (the updated pointer).
    assign base    = (state == WRITE) ? win_inc : rr_ptr;

    always_comb begin
        int best_off;
        int off;
        elig     = '0;
        ack_next = '0;
        grant    = '0;
        sel_addr = '0;
        sel_data = '0;
        best_off = int'(NREQ);
        off      = 0;
        for (int i = 0; i < int'(NREQ); i++) begin
            elig[i]     = req_valid[i] & ~req_ack[i] & ~((state == WRITE) && (win == IW'(i)));
            ack_next[i] = (state == WRITE) && (win == IW'(i));
            off = (i + int'(NREQ) - int'(base)) % int'(NREQ);
            if (elig[i] && (off < best_off)) begin
                best_off = off;
                grant    = IW'(i);
                sel_addr = req_addr[2*i +: 2];
                sel_data = req_data[DW*i +: DW];
            end
        end
        found = (best_off < int'(NREQ));
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (found) next_state = WRITE;
            WRITE:   next_state = found ? WRITE : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

`ifdef WR_ARB_ACCUM_EN
    assign wdata = regs[lat_addr] + lat_data;
`else
    assign wdata = lat_data;
`endif

    // Commit the latched write and latch the next winner on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            req_ack    <= '0;
            busy       <= 1'b0;
            commit_cnt <= '0;
            rr_ptr     <= '0;
            win        <= '0;
            lat_addr   <= '0;
            lat_data   <= '0;
        end else begin
            busy    <= (next_state == WRITE);
            req_ack <= ack_next;
            if (found) begin
                win      <= grant;
                lat_addr <= sel_addr;
                lat_data <= sel_data;
            end
            if (state == WRITE) begin
                regs[lat_addr] <= wdata;
                commit_cnt     <= commit_cnt + CW'(1);
                rr_ptr         <= win_inc;
            end
        end
    end

    assign a = regs[0];
    assign b = regs[1];
    assign c = regs[2];
    assign d = regs[3];

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: per-cycle compare against a request-level model plus literal checks.
module tb_reg_write_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned CW   = 8;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [2*NREQ-1:0]    req_addr;
    logic [DW*NREQ-1:0]   req_data;
    logic [NREQ-1:0]      req_ack;
    logic [DW-1:0]        a, b, c, d;
    logic                 busy;
    logic [CW-1:0]        commit_cnt;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 0;

    reg_write_arbiter #(.NREQ(NREQ), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ack(req_ack), .a(a), .b(b), .c(c), .d(d),
        .busy(busy), .commit_cnt(commit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Request-level model: one pending grant, a pointer, four registers, a commit count.
    int m_pend   = -1;
    int m_rr     = 0;
    int m_cnt    = 0;
    int m_ack    = 0;
    int m_addr   = 0;
    int m_data   = 0;
    int m_reg[4] = '{0, 0, 0, 0};

    always @(posedge clk or negedge rst) begin
        int old_ack;
        int old_pend;
        int w;
        if (!rst) begin
            m_pend = -1; m_rr = 0; m_cnt = 0; m_ack = 0;
            for (int i = 0; i < 4; i++) m_reg[i] = 0;
        end else begin
            old_ack  = m_ack;
            old_pend = m_pend;
            m_ack    = 0;
            if (old_pend >= 0) begin
`ifdef WR_ARB_ACCUM_EN
                m_reg[m_addr] = (m_reg[m_addr] + m_data) % 256;
`else
                m_reg[m_addr] = m_data;
`endif
                m_ack = 1 << old_pend;
                m_rr  = (old_pend + 1) % int'(NREQ);
                m_cnt = (m_cnt + 1) % 256;
            end
            w = -1;
            for (int k = 0; k < int'(NREQ); k++) begin
                int j;
                j = (m_rr + k) % int'(NREQ);
                if (w < 0 && req_valid[j] && !old_ack[j] && j != old_pend) w = j;
            end
            if (w >= 0) begin
                m_addr = int'(req_addr[2*w +: 2]);
                m_data = int'(req_data[DW*w +: DW]);
            end
            m_pend = w;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a", int'(a), m_reg[0]);
            chk("b", int'(b), m_reg[1]);
            chk("c", int'(c), m_reg[2]);
            chk("d", int'(d), m_reg[3]);
            chk("busy", int'(busy), int'(m_pend >= 0));
            chk("commit_cnt", int'(commit_cnt), m_cnt);
            chk("req_ack", int'(req_ack), m_ack);
        end
    end

    // Advance one edge, then behave like requesters: drop valid once acked.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(NREQ); i++)
            if (req_ack[i]) req_valid[i] = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [1:0] ad, input logic [DW-1:0] dt);
        req_addr[2*i +: 2]  = ad;
        req_data[DW*i +: DW] = dt;
        req_valid[i]        = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        repeat (2) step();
        chk_en = 1;
        rst    = 1'b1;
        repeat (5) step();
        chk("rst_a", int'(a), 0);
        chk("rst_d", int'(d), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cnt", int'(commit_cnt), 0);
        chk("rst_ack", int'(req_ack), 0);

        // single requester
        set_req(0, 2'd0, 8'd17);
        step();
        chk("single_busy", int'(busy), 1);
        chk("single_a_pre", int'(a), 0);
        step();
        chk("single_a", int'(a), 17);
        chk("single_ack", int'(req_ack), 1);
        chk("single_cnt", int'(commit_cnt), 1);
        chk("single_idle", int'(busy), 0);
        step();
        chk("single_ack_off", int'(req_ack), 0);

        // all four at once from rr_ptr=0
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        for (int i = 0; i < 4; i++) set_req(i, 2'(i), 8'(16 + i));
        step();
        chk("all_busy", int'(busy), 1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("all_ack_order", int'(req_ack), 1 << k);
            chk("all_busy_gap", int'(busy), int'(k < 3));
        end
        chk("all_a", int'(a), 16);
        chk("all_b", int'(b), 17);
        chk("all_c", int'(c), 18);
        chk("all_d", int'(d), 19);
        chk("all_cnt", int'(commit_cnt), 4);

        // move rr_ptr to 2, then two writers to c
        set_req(1, 2'd0, 8'h55);
        repeat (3) step();
        chk("rr_a", int'(a), 8'h55);
        set_req(1, 2'd2, 8'd5);
        set_req(3, 2'd2, 8'd9);
        step();
        step();
        chk("same_first_ack", int'(req_ack), 8);
        chk("same_first_c", int'(c), 9);
        step();
        chk("same_second_ack", int'(req_ack), 2);
        chk("same_final_c", int'(c), 5);
        step();
        chk("same_idle", int'(busy), 0);

        // reset in the middle of a WRITE
        set_req(2, 2'd1, 8'd7);
        step();
        chk("mid_busy", int'(busy), 1);
        #3 rst = 1'b0;
        #1;
        chk("mid_rst_a", int'(a), 0);
        chk("mid_rst_c", int'(c), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_cnt", int'(commit_cnt), 0);
        chk("mid_rst_ack", int'(req_ack), 0);
        step();
        rst = 1'b1;
        step();
        step();
        chk("mid_b", int'(b), 7);
        chk("mid_ack", int'(req_ack), 4);
        chk("mid_cnt", int'(commit_cnt), 1);
        repeat (3) step();
        chk("mid_once_cnt", int'(commit_cnt), 1);

        // d=250 then +10
        set_req(3, 2'd3, 8'd250);
        repeat (3) step();
        chk("acc_d250", int'(d), 250);
        set_req(3, 2'd3, 8'd10);
        repeat (3) step();
`ifdef WR_ARB_ACCUM_EN
        chk("acc_wrap_d", int'(d), 4);
`else
        chk("acc_wrap_d", int'(d), 10);
`endif
        chk("end_cnt", int'(commit_cnt), 3);

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Round-robin write arbiter and sequencer for a shared bank of four 8-bit result registers a, b, c, d, which the generated top drives to its outputs.
- Up to NREQ independent sequential blocks request writes using a valid/ack handshake. The arbiter serialises the writes, commits one per cycle and acknowledges each writer.
- Replaces ad-hoc multi-driver register assignment in generated designs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, register data width.
- CW, 8, width of the commit counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  bit i set = requester i has a pending write.
- req_addr  input  2*NREQ  slice [2i+1:2i] is the target of requester i: 0=a, 1=b, 2=c, 3=d.
- req_data  input  DW*NREQ  slice [DW*i+DW-1:DW*i] is the write data of requester i.
- req_ack  output  NREQ  registered one-hot; one-cycle pulse when requester i's write is committed.
- a  output  DW  register 0.
- b  output  DW  register 1.
- c  output  DW  register 2.
- d  output  DW  register 3.
- busy  output  1  high while in WRITE.
- commit_cnt  output  CW  total writes committed; wraps at 2^CW.

Behaviour:
- Reset (rst=0, asynchronous, effective at any time, including mid-WRITE):
  - a=b=c=d=0, req_ack=0, busy=0, commit_cnt=0.
  - rr_ptr=0; state=IDLE.
  - Any latched winner is discarded with no ack.
- Eligible set: elig[i] = req_valid[i] & ~req_ack[i] & ~(state==WRITE & win==i).
- Arbitration:
  - Round-robin: the first eligible index scanning rr_ptr, rr_ptr+1, ..., modulo NREQ.
  - At each edge where a winner is chosen, latch win, addr and data.
- FSM, IDLE:
  - Any elig -> WRITE with the winner latched.
  - Otherwise stay in IDLE, req_ack=0.
- FSM, WRITE (busy=1), on each edge:
  - Write the latched data to the addressed register.
  - Set req_ack[win]=1 and all other ack bits to 0.
  - commit_cnt += 1.
  - rr_ptr = (win+1) mod NREQ.
  - Any elig (evaluated with the updated rr_ptr) -> stay in WRITE with the new winner latched (back-to-back).
  - Otherwise -> IDLE.
- Latency:
  - req_valid sampled at edge E0 -> register updated and req_ack high after E1.
  - Throughput is 1 write/cycle under contention.
- Requester rule:
  - Hold valid, addr and data stable until ack is seen.
  - Drop valid or change to a new request by the edge following the ack cycle.
  - The ack mask guarantees no double commit.
- Simultaneous requests: served in strict round-robin order; no requester waits more than NREQ commits.
- Same target address from several requesters: each is committed in grant order; the last granted value remains.
- Register values are held when no write targets them.
- commit_cnt wraps from 2^CW-1 to 0 with no flag.
- addr is always 2 bits, so there are no out-of-range targets.

Optional Feature:
- Macro WR_ARB_ACCUM_EN.
- Defined: the commit is reg <= reg + data, truncated to DW bits (wraps modulo 2^DW); handshake and timing are unchanged.
- Undefined: the commit is a plain overwrite, reg <= data.

Test Plan:
- Reset then idle 5 cycles -> a=b=c=d=0, busy=0, commit_cnt=0, req_ack=0.
- Req 0 only: addr=0, data=17 held until ack -> a=17 and req_ack=0001 one cycle after the sample edge; commit_cnt=1; busy back to 0 next cycle.
- All 4 requesters asserted at the same edge, addr=i, data=16+i -> acks in order 0,1,2,3 on consecutive cycles; a=16, b=17, c=18, d=19; commit_cnt=4; no idle gap.
- Req 1 and req 3 both target c, data 5 and 9, rr_ptr=2 -> req 3 granted first then req 1; final c=5.
- Req 2 held valid (write b=7) with rst pulsed low mid-WRITE before its ack -> all outputs 0 immediately; after release, b=7 is written once with one ack.
- With WR_ARB_ACCUM_EN: d=250, then write d with data 10 -> d=4 (wrap). Without the macro -> d=10.
